// File: rtl/coeff_frame_loader.sv
// coeff_frame_loader: vsync-aligned 3x3 kernel loader with toggle-strobe shadow writes; COEFF_READBACK_EN adds readback
module coeff_frame_loader #(
  parameter int NUM_COEFF  = 9,
  parameter int COEFF_W    = 16,
  parameter int CENTER_IDX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vs_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        data_i,
  input  logic               wr_strobe_i,
  output logic               wr_ack_o,
  input  logic               rd_strobe_i,
  output logic               rd_ack_o,
  output logic [31:0]        rd_data_o,
  output logic [COEFF_W-1:0] coeff_o,
  output logic [3:0]         coeff_idx_o,
  output logic               coeff_we_o,
  output logic               busy_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, LOAD = 2'd2} state_t;
  localparam logic [3:0] NC   = 4'(NUM_COEFF);
  localparam logic [3:0] LAST = 4'(NUM_COEFF - 1);
  state_t state, state_n;
  logic [COEFF_W-1:0] shadow [NUM_COEFF];
  logic [COEFF_W-1:0] active [NUM_COEFF];
  logic [2:0] wr_q;
  logic vs_q, pending, wr_ack_pend, e_we;
  logic [3:0] idx, e_idx;
  logic [COEFF_W-1:0] e_coeff;
  logic [3:0] widx;
  logic wr_ev, vs_rise, copy, commit, unused_bits;
  assign widx    = addr_i[5:2];
  assign wr_ev   = wr_q[1] ^ wr_q[2];
  assign vs_rise = vs_i & ~vs_q;
  assign copy    = (state == WAIT_VS) && vs_rise;
  assign commit  = wr_ev && (widx == NC);
  always_comb begin
    state_n = state;
    state_n = (state == IDLE)    ? (pending ? WAIT_VS : IDLE) :
              (state == WAIT_VS) ? (vs_rise ? LOAD : WAIT_VS) :
                                   ((idx == LAST) ? IDLE : LOAD);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= '0;
      vs_q        <= 1'b0;
      pending     <= 1'b1;
      wr_ack_pend <= 1'b0;
      wr_ack_o    <= 1'b0;
      idx         <= '0;
      e_we        <= 1'b0;
      e_idx       <= '0;
      e_coeff     <= '0;
      coeff_we_o  <= 1'b0;
      coeff_idx_o <= '0;
      coeff_o     <= '0;
      busy_o      <= 1'b1;
      for (int i = 0; i < NUM_COEFF; i++) begin
        shadow[i] <= (i == CENTER_IDX) ? COEFF_W'(1) : '0;
        active[i] <= (i == CENTER_IDX) ? COEFF_W'(1) : '0;
      end
    end else begin
      wr_q        <= {wr_q[1:0], wr_strobe_i};
      vs_q        <= vs_i;
      wr_ack_pend <= wr_ev;
      wr_ack_o    <= wr_ack_o ^ wr_ack_pend;
      if (wr_ev && widx < NC) shadow[widx] <= data_i[COEFF_W-1:0];
      // a commit landing on the copy edge wins so the newer kernel still loads next frame
      pending <= commit | (pending & ~copy);
      if (copy) begin
        active <= shadow;
        idx    <= '0;
      end else if (state == LOAD) idx <= idx + 4'd1;
      e_we <= (state == LOAD);
      if (state == LOAD) begin
        e_idx   <= idx;
        e_coeff <= active[idx];
      end
      coeff_we_o  <= e_we;
      coeff_idx_o <= e_idx;
      coeff_o     <= e_coeff;
      busy_o      <= pending | (state != IDLE) | e_we | coeff_we_o;
    end
  end
`ifdef COEFF_READBACK_EN
  logic [2:0] rd_q;
  logic rd_ev, rd_ack_pend;
  assign rd_ev       = rd_q[1] ^ rd_q[2];
  assign unused_bits = ^{addr_i[7:6], addr_i[1:0], data_i[31:COEFF_W]};
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= '0;
      rd_ack_pend <= 1'b0;
      rd_ack_o    <= 1'b0;
      rd_data_o   <= '0;
    end else begin
      rd_q        <= {rd_q[1:0], rd_strobe_i};
      rd_ack_pend <= rd_ev;
      rd_ack_o    <= rd_ack_o ^ rd_ack_pend;
      if (rd_ev)
        rd_data_o <= (widx < NC)  ? 32'(shadow[widx]) :
                     (widx == NC) ? {29'b0, pending, state} : 32'b0;
    end
  end
`else
  assign unused_bits = ^{addr_i[7:6], addr_i[1:0], data_i[31:COEFF_W], rd_strobe_i};
  assign rd_ack_o    = 1'b0;
  assign rd_data_o   = '0;
`endif
endmodule

// File: tb/tb_coeff_frame_loader.sv
// tb_coeff_frame_loader: scoreboard bench for coeff_frame_loader; define COEFF_READBACK_EN to cover readback
module tb_coeff_frame_loader;
  logic clk = 1'b0, rst, vs_i, wr_strobe_i, rd_strobe_i;
  logic [7:0] addr_i;
  logic [31:0] data_i;
  logic wr_ack_o, rd_ack_o, coeff_we_o, busy_o;
  logic [31:0] rd_data_o;
  logic [15:0] coeff_o;
  logic [3:0] coeff_idx_o;
  int checks = 0, errors = 0, ack_cnt = 0, exp_acks = 0, a0;
  logic ack_prev = 1'b0;
  logic [15:0] msh [9];
  logic mpend;
  logic [19:0] exp_q [$];
  coeff_frame_loader dut (
    .clk(clk), .rst(rst), .vs_i(vs_i), .addr_i(addr_i), .data_i(data_i),
    .wr_strobe_i(wr_strobe_i), .wr_ack_o(wr_ack_o), .rd_strobe_i(rd_strobe_i),
    .rd_ack_o(rd_ack_o), .rd_data_o(rd_data_o), .coeff_o(coeff_o),
    .coeff_idx_o(coeff_idx_o), .coeff_we_o(coeff_we_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (wr_ack_o !== ack_prev) ack_cnt++;
    ack_prev = wr_ack_o;
    if (!rst && coeff_we_o) begin
      if (exp_q.size() == 0) chk("extra_we", {12'b0, coeff_idx_o, coeff_o}, 32'hFFFFFFFF);
      else chk("coeff", {12'b0, coeff_idx_o, coeff_o}, {12'b0, exp_q.pop_front()});
    end
  end
  task automatic send_wr(input logic [7:0] a, input logic [31:0] d);
    addr_i = a;
    data_i = d;
    wr_strobe_i = ~wr_strobe_i;
    exp_acks++;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    send_wr(a, d);
    for (int i = 0; i < 12 && ack_cnt != exp_acks; i++) @(negedge clk);
    chk("wr_ack", ack_cnt, exp_acks);
    if (a[5:2] < 9) msh[a[5:2]] = d[15:0];
    else if (a[5:2] == 9) mpend = 1'b1;
  endtask
  task automatic vs_start();
    logic loaded;
    vs_i = 1'b1;
    loaded = mpend;
    if (mpend) for (int i = 0; i < 9; i++) exp_q.push_back({4'(i), msh[i]});
    mpend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (loaded) chk("we_early", coeff_we_o, 1'b0);
    @(negedge clk);
    if (loaded) chk("we_start", coeff_we_o, 1'b1);
  endtask
  task automatic vs_end();
    repeat (14) @(negedge clk);
    vs_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask
  task automatic vs_pulse();
    vs_start();
    vs_end();
  endtask
`ifdef COEFF_READBACK_EN
  task automatic rd(input logic [7:0] a, input logic [31:0] exp);
    logic r0;
    r0 = rd_ack_o;
    addr_i = a;
    rd_strobe_i = ~rd_strobe_i;
    for (int i = 0; i < 12 && rd_ack_o == r0; i++) @(negedge clk);
    chk("rd_ack", rd_ack_o, ~r0);
    chk("rd_data", rd_data_o, exp);
  endtask
`endif
  initial begin
    rst = 1'b1; vs_i = 1'b0; addr_i = '0; data_i = '0; wr_strobe_i = 1'b0; rd_strobe_i = 1'b0;
    for (int i = 0; i < 9; i++) msh[i] = (i == 4) ? 16'd1 : 16'd0;
    mpend = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we", coeff_we_o, 1'b0);
    chk("rst_ack", wr_ack_o, 1'b0);
    chk("rst_coeff", {coeff_idx_o, coeff_o}, 20'h0);
    chk("rst_rd", {rd_ack_o, rd_data_o}, 33'h0);
    chk("rst_busy", busy_o, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("busy_init", busy_o, 1'b1);
    repeat (4) @(negedge clk);
    vs_pulse();
    chk("busy_identity", busy_o, 1'b0);
    a0 = ack_cnt;
    for (int i = 0; i < 9; i++) wr(8'(i * 4), 32'h10 + i);
    wr(8'h24, 0);
    chk("acks10", ack_cnt - a0, 10);
    repeat (3) @(negedge clk);
    chk("busy_pending", busy_o, 1'b1);
    vs_pulse();
    chk("busy_after", busy_o, 1'b0);
    wr(8'h0C, 32'hAAAA);
    wr(8'h30, 32'hDEAD);
    for (int k = 0; k < 2; k++) begin
      vs_pulse();
      chk("busy_nocommit", busy_o, 1'b0);
    end
    wr(8'h24, 0);
    repeat (3) @(negedge clk);
    vs_start();
    send_wr(8'h00, 32'h77);
    msh[0] = 16'h77;
    repeat (3) @(negedge clk);
    send_wr(8'h24, 0);
    mpend = 1'b1;
    vs_end();
    chk("busy_between", busy_o, 1'b1);
    vs_pulse();
    chk("busy_reload", busy_o, 1'b0);
    wr(8'h24, 0);
    repeat (3) @(negedge clk);
    send_wr(8'h08, 32'h5555);
    @(negedge clk);
    @(negedge clk);
    vs_start();
    msh[2] = 16'h5555;
    vs_end();
    chk("busy_race", busy_o, 1'b0);
    wr(8'h24, 0);
    repeat (3) @(negedge clk);
    vs_pulse();
`ifdef COEFF_READBACK_EN
    wr(8'h08, 32'h1234);
    rd(8'h08, 32'h1234);
    wr(8'h24, 0);
    repeat (3) @(negedge clk);
    rd(8'h24, 32'h5);
    rd(8'h3C, 32'h0);
    vs_pulse();
`endif
    repeat (5) @(negedge clk);
    chk("acks_total", ack_cnt, exp_acks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
